// File: rtl/xbar_sequencer.sv
// Micro-program sequencer for an N x N memristor crossbar: issues CLR/IMP
// operations one at a time and captures the crossbar state on HALT.
module xbar_sequencer #(
  parameter int N     = 3,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(N*N+1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [2+2*IW-1:0]     prog_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [N*N-1:0]        result,
  output logic [N*N-1:0]        xb_clear,
  output logic [N*N*IW-1:0]     xb_sel,
  input  logic [N*N-1:0]        xb_q
);

  localparam int              CELLS = N*N;
  localparam int              IN_W  = 2+2*IW;
  localparam logic [IW-1:0]   HOLD  = IW'(CELLS);
  localparam logic [AW-1:0]   LAST  = AW'(DEPTH-1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_CAPTURE} state_e;
  typedef enum logic [1:0] {OP_NOP, OP_CLR, OP_IMP, OP_HALT} op_e;

  logic [IN_W-1:0]       mem [DEPTH];
  state_e                state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic                  err_q, err_d;
  op_e                   op_q;
  logic                  ill_q;
  logic [CELLS-1:0]      result_q;
  logic [CELLS-1:0]      clr_q, clr_d;
  logic [CELLS*IW-1:0]   sel_q, sel_d;

  logic [IN_W-1:0]       fetch_w;
  op_e                   f_op;
  logic [IW-1:0]         f_dst, f_src;
  logic                  f_ill;

  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && prog_we) mem[prog_addr] <= prog_data;
  end

  assign fetch_w = mem[pc_q];
  assign f_op    = op_e'(fetch_w[IN_W-1 -: 2]);
  assign f_dst   = fetch_w[2*IW-1 -: IW];
  assign f_src   = fetch_w[IW-1:0];
  assign f_ill   = ((f_op == OP_CLR || f_op == OP_IMP) && f_dst >= HOLD) ||
                   (f_op == OP_IMP && f_src >= HOLD);

  // Drive is decoded during FETCH and registered, so it appears exactly in ISSUE.
  always_comb begin
    clr_d = '0;
    sel_d = {CELLS{HOLD}};
    if (state_q == S_FETCH && !f_ill) begin
      for (int k = 0; k < CELLS; k++) begin
        if (f_dst == IW'(k)) begin
          if (f_op == OP_CLR) clr_d[k] = 1'b1;
          if (f_op == OP_IMP) sel_d[k*IW +: IW] = f_src;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (ill_q) err_d = 1'b1;
        if (op_q == OP_HALT) begin
          state_d = S_CAPTURE;
        end else if (pc_q == LAST) begin
          err_d   = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      err_q    <= 1'b0;
      op_q     <= OP_NOP;
      ill_q    <= 1'b0;
      result_q <= '0;
      clr_q    <= '0;
      sel_q    <= {CELLS{HOLD}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      sel_q   <= sel_d;
      if (state_q == S_FETCH) begin
        op_q  <= f_op;
        ill_q <= f_ill;
      end
      if (state_q == S_CAPTURE) result_q <= xb_q;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_CAPTURE);
  assign err      = err_q;
  assign result   = result_q;
  assign xb_clear = clr_q;
  assign xb_sel   = sel_q;

endmodule

// File: tb/tb_xbar_sequencer.sv
// Bench for xbar_sequencer: behavioural crossbar, table vectors, corner
// sequences and random programs checked against a program-level model.
module tb_xbar_sequencer;

  localparam logic [35:0] IDLE36 = {9{4'd9}};

  logic        clock = 1'b0;
  logic        reset_n;
  logic        prog_we, start;
  logic [3:0]  prog_addr;
  logic [9:0]  prog_data;
  logic        busy, done, err;
  logic [8:0]  result, xb_clear, xb_q;
  logic [35:0] xb_sel;

  logic        d_we, d_start, d_busy, d_done, d_err;
  logic [1:0]  d_addr;
  logic [9:0]  d_data;
  logic [8:0]  d_result, d_clear;
  logic [8:0]  d_q = 9'h0AA;
  logic [35:0] d_sel;

  always #5 clock = ~clock;

  xbar_sequencer #(.N(3), .DEPTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .done(done), .err(err),
    .result(result), .xb_clear(xb_clear), .xb_sel(xb_sel), .xb_q(xb_q));

  xbar_sequencer #(.N(3), .DEPTH(4)) u_d4 (
    .clock(clock), .reset_n(reset_n), .prog_we(d_we), .prog_addr(d_addr),
    .prog_data(d_data), .start(d_start), .busy(d_busy), .done(d_done), .err(d_err),
    .result(d_result), .xb_clear(d_clear), .xb_sel(d_sel), .xb_q(d_q));

  // Crossbar: clear wins; otherwise cell <= ~Y | cell with Y = cells[sel] (sel=9 -> Y=1, hold)
  logic [8:0] cells;
  logic       pl_en = 1'b0;
  logic [8:0] pl_val = '0;
  always @(posedge clock) begin
    if (pl_en) cells <= pl_val;
    else for (int k = 0; k < 9; k++) begin
      logic [3:0] s;
      s = xb_sel[k*4 +: 4];
      if (xb_clear[k]) cells[k] <= 1'b0;
      else if (s < 4'd9) cells[k] <= ~cells[s] | cells[k];
    end
  end
  assign xb_q = cells;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] enc(input int op, input int d, input int s);
    return {op[1:0], d[3:0], s[3:0]};
  endfunction

  // Program-level reference model
  logic [9:0]  mprog [16];
  logic [8:0]  m_clr [16];
  logic [35:0] m_sel [16];

  task automatic model(input logic [8:0] init, output logic [8:0] res,
                       output logic e, output int m);
    logic [8:0] c;
    logic [1:0] op;
    logic [3:0] d, s;
    c = init; e = 1'b0; m = 0;
    for (int pc = 0; pc < 16; pc++) begin
      op = mprog[pc][9:8]; d = mprog[pc][7:4]; s = mprog[pc][3:0];
      m_clr[pc] = '0; m_sel[pc] = IDLE36; m = pc + 1;
      if (op == 2'd3) break;
      if (op == 2'd1) begin
        if (d < 9) begin m_clr[pc][d] = 1'b1; c[d] = 1'b0; end
        else e = 1'b1;
      end else if (op == 2'd2) begin
        if (d < 9 && s < 9) begin m_sel[pc][d*4 +: 4] = s; c[d] = ~c[s] | c[d]; end
        else e = 1'b1;
      end
      if (pc == 15) e = 1'b1;
    end
    res = c;
  endtask

  task automatic preload(input logic [8:0] v);
    @(negedge clock); pl_en = 1'b1; pl_val = v;
    @(negedge clock); pl_en = 1'b0;
  endtask

  task automatic load_prog(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clock); prog_we = 1'b1; prog_addr = 4'(i); prog_data = mprog[i];
    end
    @(negedge clock); prog_we = 1'b0;
  endtask

  logic [8:0]  clr_log [128];
  logic [35:0] sel_log [128];

  // Cycle 1 is the cycle in which start is sampled; cyc is the cycle index at which done is seen.
  task automatic wait_done(input int c0, input int inj, output int cyc);
    cyc = c0;
    while (cyc < 120) begin
      clr_log[cyc] = xb_clear; sel_log[cyc] = xb_sel;
      if (done) break;
      if (cyc == inj) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = enc(3, 0, 0);
      end else if (cyc == inj + 1) begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(negedge clock); cyc++;
    end
    if (cyc >= 120) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 120 cycles");
    end
  endtask

  task automatic run_prog(input int inj, output int cyc);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done(2, inj, cyc);
  endtask

  typedef struct {
    int         len;
    logic [9:0] w [4];
    logic [8:0] pre;
    logic [8:0] res;
    logic       e;
    int         cyc;
  } vec_t;
  vec_t tv [6];

  task automatic setv(input int i, input int len, input logic [9:0] w0, input logic [9:0] w1,
                      input logic [9:0] w2, input logic [9:0] w3, input logic [8:0] pre,
                      input logic [8:0] res, input logic e, input int cyc);
    tv[i].len = len; tv[i].w[0] = w0; tv[i].w[1] = w1; tv[i].w[2] = w2; tv[i].w[3] = w3;
    tv[i].pre = pre; tv[i].res = res; tv[i].e = e; tv[i].cyc = cyc;
  endtask

  initial begin
    int cyc, m;
    logic [8:0] eres, snap;
    logic ee;

    setv(0, 4, enc(1,0,0), enc(1,1,0), enc(2,1,0), enc(3,0,0), 9'h1FF, 9'h1FE, 1'b0, 10);
    setv(1, 3, enc(1,4,0), enc(2,4,12), enc(3,0,0), 10'h0, 9'h1FF, 9'h1EF, 1'b1, 8);
    setv(2, 3, enc(1,8,0), enc(2,8,8), enc(3,0,0), 10'h0, 9'h000, 9'h100, 1'b0, 8);
    setv(3, 3, enc(2,0,3), enc(0,0,0), enc(3,0,0), 10'h0, 9'h0F0, 9'h0F1, 1'b0, 8);
    setv(4, 2, enc(1,9,0), enc(3,0,0), 10'h0, 10'h0, 9'h155, 9'h155, 1'b1, 6);
    setv(5, 2, enc(2,2,9), enc(3,0,0), 10'h0, 10'h0, 9'h000, 9'h000, 1'b1, 6);

    reset_n = 1'b0; prog_we = 1'b0; start = 1'b0; prog_addr = '0; prog_data = '0;
    d_we = 1'b0; d_start = 1'b0; d_addr = '0; d_data = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_result", result, 0); chk("rst_clear", xb_clear, 0); chk("rst_sel", xb_sel, IDLE36);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) mprog[j] = tv[i].w[j];
      preload(tv[i].pre);
      load_prog(tv[i].len);
      run_prog(-1, cyc);
      chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(tv[i].cyc));
      chk($sformatf("v%0d_err", i), err, tv[i].e);
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), {busy, done}, 2'b00);
      chk($sformatf("v%0d_result", i), result, tv[i].res);
      if (i == 0) begin
        chk("basic_clr0", clr_log[3], 9'b000000001);
        chk("basic_clr_gap", clr_log[4], 9'b0);
        chk("basic_clr1", clr_log[5], 9'b000000010);
        chk("basic_imp_sel", sel_log[7], 36'h999999909);
        chk("basic_imp_clr", clr_log[7], 9'b0);
      end
      if (i == 1) begin
        chk("hold_clr4", clr_log[3], 9'h010);
        chk("illegal_imp_sel", sel_log[5], IDLE36);
      end
    end

    // Reset in the ISSUE cycle of an IMP
    mprog[0] = enc(1,12,0); mprog[1] = enc(2,1,0); mprog[2] = enc(3,0,0);
    preload(9'h0F0);
    load_prog(3);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst_err", err, 1'b1);
    chk("pre_rst_imp_sel", xb_sel, 36'h999999909);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0); chk("midrst_err", err, 0);
    chk("midrst_result", result, 0); chk("midrst_clear", xb_clear, 0);
    chk("midrst_sel", xb_sel, IDLE36);
    @(negedge clock); reset_n = 1'b1;
    chk("midrst_cells_kept", cells, 9'h0F0);
    for (int j = 3; j < 16; j++) mprog[j] = enc(3,0,0);
    snap = 9'h0F0;
    model(snap, eres, ee, m);
    run_prog(-1, cyc);
    chk("rerun_latency", 64'(cyc), 64'(2*m+2));
    chk("rerun_err", err, ee);
    @(negedge clock);
    chk("rerun_result", result, eres);

    // start and prog_we while busy are ignored
    mprog[0] = enc(1,0,0); mprog[1] = enc(3,0,0);
    preload(9'h1FF);
    load_prog(2);
    run_prog(3, cyc);
    chk("busy_latency", 64'(cyc), 64'd6);
    @(negedge clock);
    chk("busy_result", result, 9'h1FE);
    chk("busy_no_restart", busy, 1'b0);
    preload(9'h1FF);
    run_prog(-1, cyc);
    @(negedge clock);
    chk("busy_rerun_result", result, 9'h1FE);

    // Back-to-back start in the IDLE cycle after done, with a same-cycle write
    mprog[0] = enc(1,12,0); mprog[1] = enc(2,8,8); mprog[2] = enc(3,0,0);
    preload(9'h000);
    load_prog(3);
    run_prog(-1, cyc);
    @(negedge clock);
    chk("b2b_idle_busy", busy, 1'b0);
    chk("b2b_prev_err", err, 1'b1);
    chk("b2b_prev_result", result, 9'h100);
    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = enc(1,8,0);
    @(negedge clock);
    start = 1'b0; prog_we = 1'b0;
    chk("b2b_busy_rise", busy, 1'b1);
    chk("b2b_err_cleared", err, 1'b0);
    wait_done(2, -1, cyc);
    chk("b2b_latency", 64'(cyc), 64'd8);
    chk("b2b_clr8", clr_log[3], 9'h100);
    chk("b2b_imp_sel", sel_log[5], 36'h899999999);
    @(negedge clock);
    chk("b2b_result", result, 9'h100);
    chk("b2b_err", err, 1'b0);

    // Random programs against the model
    for (int r = 0; r < 24; r++) begin
      for (int j = 0; j < 16; j++) begin
        int k, op;
        k = $urandom_range(0, 9);
        op = (k < 2) ? 0 : (k < 5) ? 1 : (k < 9) ? 2 : 3;
        mprog[j] = enc(op, $urandom_range(0, 10), $urandom_range(0, 10));
      end
      snap = 9'($urandom_range(0, 511));
      preload(snap);
      load_prog(16);
      model(snap, eres, ee, m);
      run_prog(-1, cyc);
      chk($sformatf("rnd%0d_latency", r), 64'(cyc), 64'(2*m+2));
      for (int i = 0; i < m; i++) begin
        chk($sformatf("rnd%0d_clr%0d", r, i), clr_log[2*i+3], m_clr[i]);
        chk($sformatf("rnd%0d_sel%0d", r, i), sel_log[2*i+3], m_sel[i]);
      end
      @(negedge clock);
      chk($sformatf("rnd%0d_err", r), err, ee);
      chk($sformatf("rnd%0d_result", r), result, eres);
    end

    // Run-off on a DEPTH=4 instance: four NOPs, no HALT
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); d_we = 1'b1; d_addr = 2'(i); d_data = '0;
    end
    @(negedge clock); d_we = 1'b0;
    @(negedge clock); d_start = 1'b1;
    @(negedge clock); d_start = 1'b0;
    cyc = 2;
    while (!d_done && cyc < 60) begin
      chk($sformatf("runoff_idle_drive_c%0d", cyc), {d_clear, d_sel}, {9'b0, IDLE36});
      @(negedge clock); cyc++;
    end
    chk("runoff_latency", 64'(cyc), 64'd10);
    chk("runoff_err", d_err, 1'b1);
    @(negedge clock);
    chk("runoff_result", d_result, 9'h0AA);
    chk("runoff_busy_fall", d_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/xbar_sequencer.md
Name: xbar_sequencer

Overview:
- Drives the memristor crossbar's control interface (per-cell clear, per-cell source select) and reads back its state bus.
- Holds a small loaded micro-program of CLR/IMP operations and issues one operation at a time to the crossbar.
- On HALT it captures the crossbar state into a result register and raises done.
- Sits between the host/bus side and one crossbar instance; `xb_q` is the crossbar's Q bus.

Parameters:
- N, 3, crossbar dimension (N×N cells); must match the crossbar instance.
- DEPTH, 16, program memory depth in instructions (power of two, ≥2).
- IW, $clog2(N*N+1), derived cell-index width; value N*N is the crossbar's "no source / hold" code.
- AW, $clog2(DEPTH), derived program address width.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  program write strobe; accepted only in IDLE.
- prog_addr  in  AW  program write address.
- prog_data  in  2+2*IW  instruction as {op[1:0], dst[IW-1:0], src[IW-1:0]}.
- start  in  1  begin execution at address 0; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is captured.
- err  out  1  sticky until the next accepted start; set on an illegal index or on running off the end of the program.
- result  out  N*N  captured crossbar state; bit k = cell (k/N, k%N).
- xb_clear  out  N*N  to crossbar clear; bit k = cell (k/N, k%N).
- xb_sel  out  N*N*IW  to crossbar sel; field k = select of cell k.
- xb_q  in  N*N  crossbar Q bus; same bit mapping.

Behaviour:
- Opcodes:
  - 00 NOP.
  - 01 CLR: clear cell dst.
  - 10 IMP: dst <= ~src | dst.
  - 11 HALT.
- Idle drive:
  - xb_clear = 0.
  - Every xb_sel field = N*N, so the crossbar sees Y=1 and every cell holds.
  - This drive is present whenever no instruction is being issued.
- Reset (async, reset_n=0):
  - State returns to IDLE; busy=0, done=0, err=0, result=0, pc=0.
  - xb_* outputs return to the idle drive.
  - Program memory contents are not reset.
  - A reset mid-program abandons execution; crossbar cells keep whatever was already committed.
- States: IDLE, FETCH, ISSUE, CAPTURE.
- IDLE:
  - A prog_we writes prog_data into mem[prog_addr].
  - start=1 clears err, sets pc=0 and moves to FETCH.
  - If prog_we and start arrive together, the write completes and start is accepted in the same cycle.
- FETCH (1 cycle): synchronous read of mem[pc] into the instruction register.
- ISSUE (1 cycle): outputs are registered, so this cycle shows the instruction's drive:
  - CLR: xb_clear bit dst = 1, all sel fields idle.
  - IMP: xb_sel field dst = src, all other fields idle, xb_clear = 0.
  - NOP: idle drive.
  - HALT: idle drive, then go to CAPTURE instead of fetching.
  - The crossbar commits at the posedge ending ISSUE.
  - After any non-HALT instruction, pc increments and the state returns to FETCH.
  - Cost: 2 cycles per instruction.
- Illegal index:
  - CLR with dst ≥ N*N, or IMP with dst ≥ N*N or src ≥ N*N.
  - Sets err, issues the idle drive in place of the instruction, and execution continues.
  - IMP with src == dst is legal (forces the cell to 1).
- End of program:
  - If pc = DEPTH-1 is issued and is not HALT, set err and go to CAPTURE. No wrap-around.
- CAPTURE (1 cycle):
  - The idle drive is already applied.
  - result <= xb_q; done pulses high for this cycle.
  - busy falls on the following edge and the state returns to IDLE.
- busy:
  - 1 in FETCH, ISSUE and CAPTURE; 0 in IDLE.
  - The first busy cycle is the cycle after start is sampled.
- Ignored while busy: start and prog_we (no memory write, no restart).
- Latency:
  - start → done = 2*M + 2 cycles, where M = number of instructions including HALT.
  - Example: 4 instructions → done pulses 10 cycles after start is sampled.
- result holds its value until the next CAPTURE or reset.

Test Plan (N=3, idle sel=9):
- Reset values: assert reset_n=0 mid-ISSUE of an IMP → same cycle busy=0, done=0, err=0, result=0, xb_clear=0, all xb_sel=9; after release, start re-runs the stored program correctly.
- Basic program:
  - Program: CLR 0; CLR 1; IMP dst=1 src=0; HALT.
  - Required: xb_clear=9'b000000001 for exactly one cycle, then 9'b000000010.
  - Then xb_sel field1=0 with all others 9.
  - done 10 cycles after start; result bit1=1, bit0=0.
- Hold and illegal index:
  - Program: CLR 4; IMP dst=4 src=12; HALT, on a crossbar preloaded with all ones.
  - Required: err=1 and no IMP drive (all sel=9).
  - result = 9'b111101111.
- Run-off, DEPTH=4:
  - Program: NOP, NOP, NOP, NOP with no HALT.
  - Required: err=1 and done 2*4+2 = 10 cycles after start.
- Busy protection:
  - Pulse start and prog_we at addr 0 while busy.
  - Required: no restart, mem[0] unchanged, and a later rerun gives an identical result.
- Self-IMP and back-to-back:
  - Program: CLR 8; IMP 8←8; HALT.
  - Required: result bit8=1.
  - A start on the cycle after the done pulse (IDLE) is accepted, busy rises the next cycle, and err from the prior run is cleared.
